// File: rtl/chipmuenk_audio_pkg.sv
// Shared constants for the chipmuenk audio I/O tile: default rates and the
// 7-segment hex glyph table (segments g..a, active-high, bit0 = a).
package chipmuenk_audio_pkg;

  localparam int OSR_LOG2_DEF   = 6;
  localparam int DECAY_LOG2_DEF = 20;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_ZERO  = 7'h3F;

  localparam logic [6:0] SEG_TABLE [16] = '{
    SEG_ZERO, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F,    7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Hex digit to glyph lookup; anything not matched stays blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    seg = SEG_BLANK;
    for (int i = 0; i < 16; i++) begin
      if (digit == 4'(i)) seg = SEG_TABLE[i];
    end
    return seg;
  endfunction

endpackage

// File: rtl/sigma_delta_dac.sv
// First-order sigma-delta (PDM) DAC. The signed sample is captured on the
// sample strobe, converted to offset binary and integrated every clock; the
// accumulator carry is the PDM bit, so ones density equals xu/256.
module sigma_delta_dac (
  input  logic               clk,
  input  logic               rst,
  input  logic               strobe,
  input  logic [7:0]         ui_in,
  output logic signed [7:0]  sample,
  output logic               pdm
);

  logic signed [7:0] sample_p0;
  logic [7:0]        acc_p1;
  logic              pdm_p2;
  logic [7:0]        xu;
  logic [8:0]        sum;

  // Two's complement to offset binary: flipping the sign bit maps -128..127
  // onto 0..255.
  function automatic logic [7:0] to_offset(input logic signed [7:0] s);
    return {~s[7], s[6:0]};
  endfunction

  assign xu  = to_offset(sample_p0);
  assign sum = {1'b0, acc_p1} + {1'b0, xu};

  // Sample capture, accumulator update and carry-to-PDM register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_p0 <= '0;
      acc_p1    <= '0;
      pdm_p2    <= 1'b0;
    end else begin
      if (strobe) sample_p0 <= signed'(ui_in);
      acc_p1 <= sum[7:0];
      pdm_p2 <= sum[8];
    end
  end

  assign sample = sample_p0;
  assign pdm    = pdm_p2;

endmodule

// File: rtl/chipmuenk_audio_io.sv
// Audio I/O tile core: PDM DAC, optional external-comparator sigma-delta ADC
// and a decaying peak meter shown as one hex digit on the 7-segment display.
// Optional feature macro: CHIPMUENK_ADC_EN (ADC path on the uio pins and the
// uio_in[7] meter-source select). Without it uio_in is ignored and the uio
// pins are never driven. OSR_LOG2 is meant to lie in 1..8.
module chipmuenk_audio_io
  import chipmuenk_audio_pkg::*;
#(
  parameter int OSR_LOG2   = OSR_LOG2_DEF,
  parameter int DECAY_LOG2 = DECAY_LOG2_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [OSR_LOG2-1:0]   div_p0;
  logic                  strobe;
  logic [DECAY_LOG2-1:0] decay_cnt_p0;
  logic                  decay_tick;
  logic signed [7:0]     sample;
  logic                  pdm;
  logic signed [7:0]     src;
  logic [6:0]            mag;
  logic [6:0]            peak_p1;

  // Ones' complement magnitude: -128 maps to 127, so no overflow case.
  function automatic logic [6:0] mag_of(input logic signed [7:0] s);
    return s[7] ? ~s[6:0] : s[6:0];
  endfunction

  // One-LSB decay that holds at zero instead of wrapping.
  function automatic logic [6:0] dec_sat(input logic [6:0] p);
    return (p == 7'd0) ? 7'd0 : p - 7'd1;
  endfunction

  // Free-running sample-rate divider; strobe marks its last count.
  always_ff @(posedge clk) begin
    if (rst) div_p0 <= '0;
    else     div_p0 <= div_p0 + OSR_LOG2'(1);
  end
  assign strobe = &div_p0;

  // Independent decay timer for the peak meter.
  always_ff @(posedge clk) begin
    if (rst) decay_cnt_p0 <= '0;
    else     decay_cnt_p0 <= decay_cnt_p0 + DECAY_LOG2'(1);
  end
  assign decay_tick = &decay_cnt_p0;

  sigma_delta_dac u_dac (
    .clk    (clk),
    .rst    (rst),
    .strobe (strobe),
    .ui_in  (ui_in),
    .sample (sample),
    .pdm    (pdm)
  );

`ifdef CHIPMUENK_ADC_EN
  logic                fb_p0;
  logic [OSR_LOG2:0]   ones_p0;
  logic [7:0]          adc_p1;
  logic signed [7:0]   adc_signed;
  logic                unused_bits;

  // Scale a window ones count to 8 bits; a full window gives 256, which
  // clips to 255.
  function automatic logic [7:0] sat_u8(input logic [8:0] v);
    return v[8] ? 8'hFF : v[7:0];
  endfunction

  function automatic logic [8:0] adc_scale(input logic [OSR_LOG2:0] cnt);
    return 9'(cnt) << (8 - OSR_LOG2);
  endfunction

  // Comparator feedback register, per-window ones counter and ADC result.
  // The strobe cycle's fb opens the next window.
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_p0   <= 1'b0;
      ones_p0 <= '0;
      adc_p1  <= '0;
    end else begin
      fb_p0 <= uio_in[0];
      if (strobe) begin
        adc_p1  <= sat_u8(adc_scale(ones_p0));
        ones_p0 <= {OSR_LOG2'(0), fb_p0};
      end else begin
        ones_p0 <= ones_p0 + {OSR_LOG2'(0), fb_p0};
      end
    end
  end

  assign adc_signed  = signed'({~adc_p1[7], adc_p1[6:0]});
  assign src         = uio_in[7] ? adc_signed : sample;
  assign uio_out     = {6'b0, fb_p0, 1'b0};
  assign uio_oe      = 8'h02;
  assign unused_bits = &{1'b0, ena, uio_in[6:1]};
`else
  logic unused_bits;

  assign src         = sample;
  assign uio_out     = 8'h00;
  assign uio_oe      = 8'h00;
  assign unused_bits = &{1'b0, ena, uio_in};
`endif

  assign mag = mag_of(src);

  // Peak hold: a larger magnitude at a strobe wins over a decay step.
  always_ff @(posedge clk) begin
    if (rst)                          peak_p1 <= '0;
    else if (strobe && mag > peak_p1) peak_p1 <= mag;
    else if (decay_tick)              peak_p1 <= dec_sat(peak_p1);
  end

  assign uo_out = {pdm, seg_decode(peak_p1[6:3])};

endmodule

// File: tb/tb_chipmuenk_audio_io.sv
// Self-checking bench for chipmuenk_audio_io with OSR_LOG2=6, DECAY_LOG2=4.
`timescale 1ns/1ps
module tb_chipmuenk_audio_io;

  localparam int OSR  = 6;
  localparam int DLOG = 4;
  localparam int PER  = 1 << OSR;
  localparam int DEC  = 1 << DLOG;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  always #5 clk = ~clk;

  chipmuenk_audio_io #(.OSR_LOG2(OSR), .DECAY_LOG2(DLOG)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] seg_ref [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct { logic [7:0] ui; int ones; } dac_vec_t;
  typedef struct { logic [7:0] ui; logic [6:0] seg; } seg_vec_t;
  dac_vec_t dac_tab [6];
  seg_vec_t seg_tab [9];

  // Reference model state: cycles since reset, held sample, peak level.
  int         e = 0;
  int         m_peak = 0;
  logic [7:0] m_sample = 8'h00;
  bit         model_on = 1'b0;
`ifdef CHIPMUENK_ADC_EN
  logic       m_fb = 1'b0;
`endif

  function automatic int mag_ref(input logic [7:0] s);
    return s[7] ? 127 - int'(s[6:0]) : int'(s[6:0]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, e);
    end
  endtask

  // One clock: model follows the inputs present at the edge, outputs are
  // compared on the falling edge.
  task automatic tick();
    logic [7:0] ui_c;
    logic [7:0] uio_c;
    logic       rst_c;
    ui_c  = ui_in;
    uio_c = uio_in;
    rst_c = rst;
    @(posedge clk);
    if (rst_c) begin
      e = 0; m_peak = 0; m_sample = 8'h00;
`ifdef CHIPMUENK_ADC_EN
      m_fb = 1'b0;
`endif
    end else begin
      e++;
      if ((e % PER == 0) && (mag_ref(m_sample) > m_peak)) m_peak = mag_ref(m_sample);
      else if ((e % DEC == 0) && (m_peak > 0)) m_peak--;
      if (e % PER == 0) m_sample = ui_c;
`ifdef CHIPMUENK_ADC_EN
      m_fb = uio_c[0];
`else
      if (uio_c == 8'hxx) m_sample = m_sample;
`endif
    end
    @(negedge clk);
    if (model_on) begin
      chk("model_seg", int'(uo_out[6:0]), int'(seg_ref[m_peak / 8]));
`ifdef CHIPMUENK_ADC_EN
      chk("model_uio_out", int'(uio_out), m_fb ? 2 : 0);
`else
      chk("model_uio_out", int'(uio_out), 0);
`endif
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
  endtask

  int ones, alt_bad, hold;
  logic prev;
  logic [7:0] v;

  initial begin
    dac_tab[0] = '{8'h00, 128};
    dac_tab[1] = '{8'h80, 0};
    dac_tab[2] = '{8'h7F, 255};
    dac_tab[3] = '{8'h01, 129};
    dac_tab[4] = '{8'hFF, 127};
    dac_tab[5] = '{8'hC0, 64};

    seg_tab[0] = '{8'h7F, 7'h71};
    seg_tab[1] = '{8'h80, 7'h71};
    seg_tab[2] = '{8'hC0, 7'h07};
    seg_tab[3] = '{8'h40, 7'h7F};
    seg_tab[4] = '{8'h20, 7'h66};
    seg_tab[5] = '{8'h58, 7'h7C};
    seg_tab[6] = '{8'h10, 7'h5B};
    seg_tab[7] = '{8'hFF, 7'h3F};
    seg_tab[8] = '{8'h81, 7'h71};

    // Reset state
    ui_in = 8'h55;
    rst = 1'b1;
    repeat (4) tick();
    chk("reset_uo_out", int'(uo_out), 8'h3F);
    chk("reset_uio_out", int'(uio_out), 0);
`ifdef CHIPMUENK_ADC_EN
    chk("reset_uio_oe", int'(uio_oe), 8'h02);
`else
    chk("reset_uio_oe", int'(uio_oe), 8'h00);
`endif
    rst = 1'b0;
    model_on = 1'b1;

    // DAC ones density over 256 cycles
    for (int i = 0; i < 6; i++) begin
      do_reset();
      ui_in = dac_tab[i].ui;
      repeat (PER + 2) tick();
      ones = 0; alt_bad = 0; prev = uo_out[7];
      for (int k = 0; k < 256; k++) begin
        tick();
        ones += int'(uo_out[7]);
        if (uo_out[7] == prev) alt_bad++;
        prev = uo_out[7];
      end
      chk($sformatf("dac_ones_%02h", dac_tab[i].ui), ones, dac_tab[i].ones);
      if (dac_tab[i].ui == 8'h00) chk("dac_alternate", alt_bad, 0);
    end

    // Magnitude to glyph after the second strobe
    for (int i = 0; i < 9; i++) begin
      do_reset();
      ui_in = seg_tab[i].ui;
      repeat (2 * PER) tick();
      chk($sformatf("seg_%02h", seg_tab[i].ui), int'(uo_out[6:0]), int'(seg_tab[i].seg));
    end

    // Peak hold and decay
    do_reset();
    ui_in = 8'h7F;
    repeat (PER) tick();
    ui_in = 8'h00;
    repeat (PER) tick();
    chk("peak_hold_F", int'(uo_out[6:0]), 8'h71);
    repeat (7 * DEC) tick();
    chk("decay_7_ticks", int'(uo_out[6:0]), 8'h71);
    repeat (DEC) tick();
    chk("decay_8_ticks_E", int'(uo_out[6:0]), 8'h79);
    repeat (111 * DEC) tick();
    chk("decay_peak8", int'(uo_out[6:0]), 8'h06);
    repeat (DEC) tick();
    chk("decay_peak7", int'(uo_out[6:0]), 8'h3F);
    repeat (200) tick();
    chk("decay_floor", int'(uo_out[6:0]), 8'h3F);

    // Randomized sample stream against the model
    do_reset();
    for (int s = 0; s < 25; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0: v = 8'h00;
          1: v = 8'h7F;
          2: v = 8'h80;
          3: v = 8'hFF;
          4: v = 8'h81;
          default: v = 8'h01;
        endcase
      end else begin
        v = 8'($urandom);
      end
      ui_in = v;
      hold = int'($urandom_range(1, 200));
      for (int k = 0; k < hold; k++) begin
`ifdef CHIPMUENK_ADC_EN
        uio_in = {1'b0, 6'($urandom), 1'($urandom)};
`else
        uio_in = 8'($urandom);
`endif
        tick();
      end
    end
    uio_in = 8'h00;

    // Reset in the middle of operation
    rst = 1'b1;
    tick();
    chk("midrst_uo_out", int'(uo_out), 8'h3F);
    rst = 1'b0;
    ui_in = 8'h7F;
    repeat (2 * PER - 1) tick();
    chk("midrst_before_strobe", int'(uo_out[6:0]), 8'h3F);
    tick();
    chk("midrst_first_peak", int'(uo_out[6:0]), 8'h71);

`ifdef CHIPMUENK_ADC_EN
    // ADC path selected as meter source
    do_reset();
    model_on = 1'b0;
    ui_in = 8'h00;
    uio_in = 8'h81;
    tick();
    chk("adc_fb_delay", int'(uio_out), 8'h02);
    repeat (3 * PER - 1) tick();
    chk("adc_full_scale", int'(uo_out[6:0]), 8'h71);
    uio_in = 8'h80;
    tick();
    chk("adc_fb_low", int'(uio_out), 8'h00);
    repeat (3 * PER - 1) tick();
    chk("adc_zero_scale", int'(uo_out[6:0]), 8'h71);
    for (int k = 0; k < 2300; k++) begin
      uio_in = {1'b1, 6'b0, ~uio_in[0]};
      tick();
    end
    chk("adc_midscale_decay", int'(uo_out[6:0]), 8'h3F);
    uio_in = 8'h00;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
